// File: rtl/rf_pkg.sv
// Shared constants and helpers for the register-file write controller.
// Holds the bank geometry and the default data width.
package rf_pkg;

    localparam int NUM_REGS       = 8;
    localparam int ADDR_W         = 3;
    localparam int DEFAULT_DATA_W = 32;

    // Decode a register index into a one-hot bank write enable.
    function automatic logic [NUM_REGS-1:0] addr_to_onehot(input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] oh;
        oh       = {NUM_REGS{1'b0}};
        oh[addr] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Circular write queue for rf_write_ctrl.
// Holds storage, pointers and occupancy; caller decides push/pop.
module rf_wr_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [ADDR_W-1:0]          head_addr,
    output logic [DATA_W-1:0]          head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_mem_d [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok_s, pop_ok_s;

    // Explicit wrap so the pointer stays legal even if DEPTH is mis-set.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        push_ok_s  = push && (count_q < CNT_W'(DEPTH));
        pop_ok_s   = pop && (count_q != {CNT_W{1'b0}});

        if (push_ok_s) begin
            addr_mem_d[wr_ptr_q] = push_addr;
            data_mem_d[wr_ptr_q] = push_data;
            wr_ptr_d             = ptr_next(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_ok_s) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_q[i] <= {ADDR_W{1'b0}};
                data_mem_q[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            addr_mem_q <= addr_mem_d;
            data_mem_q <= data_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign head_addr = addr_mem_q[rd_ptr_q];
    assign head_data = data_mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/rf_write_ctrl_chk.sv
// Cycle-by-cycle invariants of rf_write_ctrl: one-hot enable, bounded occupancy, ready tracking.
module rf_write_ctrl_chk #(
    parameter int DEPTH = 4
) (
    input logic                       clk,
    input logic                       reset,
    input logic [7:0]                 en,
    input logic [$clog2(DEPTH+1)-1:0] count,
    input logic                       wr_ready
);

    localparam int CNT_W = $clog2(DEPTH+1);

    // Invariants sampled on every active edge outside reset.
    always @(posedge clk) begin
        if (!reset) begin
            a_en_onehot0: assert ($onehot0(en));
            a_count_max:  assert (count <= CNT_W'(DEPTH));
            a_ready_eq:   assert (wr_ready == (count < CNT_W'(DEPTH)));
        end
    end

endmodule

// File: rtl/rf_write_ctrl.sv
// Queued write controller for an 8-entry register bank: one registered one-hot pulse per write.
// Optional RF_WRITE_BYPASS_EN: empty-queue writes skip storage for 1-cycle latency.
module rf_write_ctrl
    import rf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       hold,
    output logic [NUM_REGS-1:0]        en,
    output logic [DATA_W-1:0]          d_in,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic                accept_s, bypass_s, push_s, pop_s, ready_s;
    logic [ADDR_W-1:0]   head_addr_s;
    logic [DATA_W-1:0]   head_data_s;
    logic [CNT_W-1:0]    count_s;
    logic [NUM_REGS-1:0] en_q, en_d;
    logic [DATA_W-1:0]   d_in_q, d_in_d;

    rf_wr_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_addr (wr_addr),
        .push_data (wr_data),
        .pop       (pop_s),
        .head_addr (head_addr_s),
        .head_data (head_data_s),
        .count     (count_s)
    );

    // Handshake, queue control and output next-state.
    always_comb begin
        ready_s  = (count_s < CNT_W'(DEPTH));
        accept_s = wr_valid && ready_s;
`ifdef RF_WRITE_BYPASS_EN
        bypass_s = accept_s && (count_s == {CNT_W{1'b0}}) && !hold;
`else
        bypass_s = 1'b0;
`endif
        push_s   = accept_s && !bypass_s;
        pop_s    = !hold && (count_s != {CNT_W{1'b0}});
        en_d     = {NUM_REGS{1'b0}};
        d_in_d   = d_in_q;

        if (pop_s) begin
            en_d   = addr_to_onehot(head_addr_s);
            d_in_d = head_data_s;
        end else if (bypass_s) begin
            en_d   = addr_to_onehot(wr_addr);
            d_in_d = wr_data;
        end else begin
            en_d   = {NUM_REGS{1'b0}};
            d_in_d = d_in_q;
        end
    end

    // Registered bank-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q   <= {NUM_REGS{1'b0}};
            d_in_q <= {DATA_W{1'b0}};
        end else begin
            en_q   <= en_d;
            d_in_q <= d_in_d;
        end
    end

    assign wr_ready = ready_s;
    assign en       = en_q;
    assign d_in     = d_in_q;
    assign count    = count_s;

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Scoreboard bench for rf_write_ctrl: directed requests push expected pulses; a monitor pops and compares.
module tb_rf_write_ctrl;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DEPTH+1);
`ifdef RF_WRITE_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_valid;
    logic             wr_ready;
    logic [2:0]       wr_addr;
    logic [31:0]      wr_data;
    logic             hold;
    logic [7:0]       en;
    logic [31:0]      d_in;
    logic [CNT_W-1:0] count;

    typedef struct {
        logic [7:0]  en;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;

    // Hand-computed vectors: full-queue test and wrap/ordering test.
    logic [2:0]  full_addr [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    logic [31:0] full_data [5] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 32'h6666_0006};
    logic [7:0]  full_en   [5] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h40};
    logic        full_rdy  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0]  wrap_addr [6] = '{3'd6, 3'd1, 3'd3, 3'd0, 3'd7, 3'd4};
    logic [31:0] wrap_data [6] = '{32'hA600_0006, 32'hA100_0001, 32'hA300_0003, 32'hA000_0000, 32'hA700_0007, 32'hA400_0004};
    logic [7:0]  wrap_en   [6] = '{8'h40, 8'h02, 8'h08, 8'h01, 8'h80, 8'h10};

    rf_write_ctrl #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .hold     (hold),
        .en       (en),
        .d_in     (d_in),
        .count    (count)
    );

    rf_write_ctrl_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .count    (count),
        .wr_ready (wr_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive(input logic [2:0] a, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
    endtask

    task automatic expect_pulse(input logic [7:0] e, input logic [31:0] d, input int due);
        exp_t x;
        x.en   = e;
        x.data = d;
        x.due  = due;
        exp_q.push_back(x);
    endtask

    task automatic monitor();
        exp_t x;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && en !== 8'h00) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got en=%h d_in=%h at cycle %0d, required no pulse", en, d_in, cyc);
                end else begin
                    x = exp_q.pop_front();
                    check("pulse_en", 32'(en), 32'(x.en));
                    check("pulse_data", d_in, x.data);
                    if (x.due >= 0) begin
                        check("pulse_cycle", cyc, x.due);
                    end
                end
            end
        end
    endtask

    initial begin
        int c0;
        int r;
        reset    = 1'b1;
        hold     = 1'b0;
        drive(3'd3, 32'hDEAD_BEEF);
        fork
            monitor();
        join_none

        // Reset with a request held on the bus: it must be dropped.
        repeat (3) tick();
        check("reset_count", 32'(count), 32'd0);
        check("reset_ready", 32'(wr_ready), 32'd1);
        check("reset_en", 32'(en), 32'd0);
        check("reset_d_in", d_in, 32'd0);
        reset    = 1'b0;
        wr_valid = 1'b0;
        repeat (3) tick();
        check("reset_req_dropped", 32'(count), 32'd0);

        // Single write into an empty queue.
        drive(3'd2, 32'hFF3F_0000);
        expect_pulse(8'h04, 32'hFF3F_0000, cyc + LAT);
        tick();
        wr_valid = 1'b0;
        check("single_count", 32'(count), (LAT == 1) ? 32'd0 : 32'd1);
        repeat (3) tick();
        check("single_en_idle", 32'(en), 32'd0);
        check("single_d_in_held", d_in, 32'hFF3F_0000);

        // Back-to-back writes keep order on consecutive cycles.
        drive(3'd0, 32'hC000_0000);
        expect_pulse(8'h01, 32'hC000_0000, cyc + LAT);
        tick();
        drive(3'd7, 32'hC700_0007);
        expect_pulse(8'h80, 32'hC700_0007, cyc + LAT);
        tick();
        drive(3'd5, 32'hC500_0005);
        expect_pulse(8'h20, 32'hC500_0005, cyc + LAT);
        tick();
        wr_valid = 1'b0;
        repeat (4) tick();
        check("order_count", 32'(count), 32'd0);

        // Fill under hold; fifth offer refused; release drains four.
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("full_ready", 32'(wr_ready), 32'(full_rdy[i]));
            drive(full_addr[i], full_data[i]);
            tick();
        end
        check("full_count", 32'(count), 32'd4);
        check("full_ready_low", 32'(wr_ready), 32'd0);
        wr_valid = 1'b0;
        hold     = 1'b0;
        r        = cyc;
        for (int i = 0; i < 4; i++) begin
            expect_pulse(full_en[i], full_data[i], r + 1 + i);
        end
        repeat (6) tick();
        check("full_drained", 32'(count), 32'd0);

        // Push and pop together at count 2; pointers wrap.
        hold = 1'b1;
        c0   = cyc;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) hold = 1'b0;
            drive(wrap_addr[i], wrap_data[i]);
            expect_pulse(wrap_en[i], wrap_data[i], c0 + 3 + i);
            tick();
            if (i >= 2) check("pushpop_count", 32'(count), 32'd2);
        end
        wr_valid = 1'b0;
        repeat (4) tick();
        check("wrap_drained", 32'(count), 32'd0);

        // Reset with three writes parked: all discarded.
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(full_addr[i], full_data[i]);
            tick();
        end
        wr_valid = 1'b0;
        check("pre_reset_count", 32'(count), 32'd3);
        reset = 1'b1;
        tick();
        check("midreset_en", 32'(en), 32'd0);
        check("midreset_d_in", d_in, 32'd0);
        check("midreset_count", 32'(count), 32'd0);
        check("midreset_ready", 32'(wr_ready), 32'd1);
        reset = 1'b0;
        hold  = 1'b0;
        repeat (6) tick();
        check("post_reset_count", 32'(count), 32'd0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_write_ctrl.md
RF_WRITE_CTRL -- requirements
Module: rf_write_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of write-queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the register data width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port wr_valid  input  1  write request present.
REQ-006 The block SHALL have port wr_ready  output  1  queue can accept a request this cycle.
REQ-007 The block SHALL have port wr_addr  input  3  target register index 0..7.
REQ-008 The block SHALL have port wr_data  input  DATA_W  write data.
REQ-009 The block SHALL have port hold  input  1  stalls draining of the queue.
REQ-010 The block SHALL have port en  output  8  one-hot write enable to the 8x32 register bank.
REQ-011 The block SHALL have port d_in  output  DATA_W  write data to the register bank.
REQ-012 The block SHALL have port count  output  $clog2(DEPTH+1)  current queue occupancy.

Function
REQ-013 A request SHALL be accepted on a rising edge where wr_valid=1 and wr_ready=1; wr_ready SHALL equal (count < DEPTH), independent of wr_valid and of a same-cycle pop.
REQ-014 Accepted requests SHALL be stored in a circular FIFO; read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-015 On each edge with hold=0 and count>0, the head entry SHALL be popped and the outputs registered: en = 1<<addr, d_in = data.
REQ-016 On an edge with no pop, en SHALL become 8'b0 and d_in SHALL hold its previous value.
REQ-017 en SHALL never have more than one bit set.
REQ-018 Writes SHALL be issued in acceptance order; each accepted request SHALL produce exactly one en pulse of one cycle.
REQ-019 Simultaneous push and pop SHALL leave count unchanged.
REQ-020 A push with no pop SHALL increment count; a pop with no push SHALL decrement count.
REQ-021 Without bypass, an accepted request at edge N into an empty queue SHALL appear on en/d_in after edge N+1 (2-cycle latency).
REQ-022 hold=1 SHALL stop pops while pushes continue up to DEPTH; release SHALL resume draining on the next edge.

Reset
REQ-023 While reset=1 at an edge: count=0, pointers=0, en=8'b0, d_in=0, and wr_ready SHALL read 1 after the edge.
REQ-024 Reset mid-operation SHALL discard all queued writes; a request presented in the reset cycle SHALL NOT be accepted.

Configuration
REQ-025 With macro RF_WRITE_BYPASS_EN defined, an accepted request with count=0 and hold=0 SHALL skip FIFO storage and drive en/d_in after the same edge (1-cycle latency), leaving count at 0.
REQ-026 Without RF_WRITE_BYPASS_EN, all requests SHALL pass through the FIFO per REQ-021.

Structure
REQ-027 A shared package rf_pkg SHALL hold NUM_REGS=8, ADDR_W=3, and the DATA_W default.
REQ-028 The queue SHALL be a sub-module rf_wr_fifo (storage, pointers, count); the one-hot decode and output registers SHALL live in rf_write_ctrl.

Verification
REQ-029 Single write with reset released: addr=2, data=32'hFF3F0000, queue empty -> en=8'b00000100, d_in=32'hFF3F0000 for exactly one cycle, 2 cycles after acceptance (1 cycle with RF_WRITE_BYPASS_EN).
REQ-030 Order check: writes to addr 0, 7, 5 on consecutive cycles -> en pulses 8'h01, 8'h80, 8'h20 on consecutive cycles with matching data.
REQ-031 Full queue: hold=1 with 5 requests offered and DEPTH=4 -> count=4, wr_ready=0, 5th not accepted; hold=0 -> 4 pulses, count returns to 0.
REQ-032 Simultaneous push and pop at count=2 -> count stays 2; pointer wrap after 6 total pushes -> data order preserved.
REQ-033 Reset mid-operation with count=3 -> en=0, d_in=0, and count=0 after the edge, with no pulses for discarded entries.
REQ-034 Assertions every cycle: $onehot0(en); count <= DEPTH; wr_ready == (count < DEPTH).
